execute_stage: RTL and testbench

Parametrised execute stage of the NPC pipeline. It sits between decode stage 2 and memory. It registers one instruction at a time, computes single-cycle ALU and multiply results, and runs a multi-cycle iterative divider. It talks to both neighbours with a valid/ready handshake, supports pipeline flush, and presents a forwarding port to decode.

---
 rtl/exe_pkg.sv | 30 +++
 rtl/exe_divider.sv | 70 +++++++
 rtl/execute_stage.sv | 186 ++++++++++++++++++
 tb/tb_execute_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: operation codes and FSM states.
package exe_pkg;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_SLL    = 6'd2;
    localparam logic [5:0] OP_SLT    = 6'd3;
    localparam logic [5:0] OP_SLTU   = 6'd4;
    localparam logic [5:0] OP_XOR    = 6'd5;
    localparam logic [5:0] OP_SRL    = 6'd6;
    localparam logic [5:0] OP_SRA    = 6'd7;
    localparam logic [5:0] OP_OR     = 6'd8;
    localparam logic [5:0] OP_AND    = 6'd9;
    localparam logic [5:0] OP_LUI    = 6'd10;
    localparam logic [5:0] OP_MUL    = 6'd16;
    localparam logic [5:0] OP_MULH   = 6'd17;
    localparam logic [5:0] OP_MULHSU = 6'd18;
    localparam logic [5:0] OP_MULHU  = 6'd19;
    localparam logic [5:0] OP_DIV    = 6'd20;
    localparam logic [5:0] OP_DIVU   = 6'd21;
    localparam logic [5:0] OP_REM    = 6'd22;
    localparam logic [5:0] OP_REMU   = 6'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } exe_state_e;

endpackage

// File: rtl/exe_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per cycle.
// start_i loads the operands; done_o pulses for one cycle with the final
// quotient/remainder. abort_i kills an iteration in flight.
module exe_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    logic            busy_q, done_q;
    logic [XLEN:0]   rem_sh, diff;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dsr_q};

    // Iteration engine: quotient bits enter from the LSB as dividend bits leave the MSB.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                busy_q <= 1'b0;
            end else if (start_i) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dsr_q  <= divisor_i;
                cnt_q  <= CW'(XLEN - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (!diff[XLEN]) begin
                    rem_q <= diff[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_q <= rem_sh[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: holds one instruction, single-cycle ALU/multiply, iterative
// divide, valid/ready on both sides, flush and a forwarding port to decode.
// Build option EXE_MULDIV_EN: when defined, multiply/divide/remainder are
// implemented; otherwise those ops complete in one cycle with result 0.
module execute_stage
    import exe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 6,
    parameter int RD_W     = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     src1_i,
    input  logic [XLEN-1:0]     src2_i,
    input  logic [RD_W-1:0]     rd_i,
    input  logic                gr_we_i,
    input  logic                res_from_mem_i,
    input  logic [XLEN-1:0]     pc_i,
    input  logic                flush_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     result_o,
    output logic [RD_W-1:0]     rd_o,
    output logic                gr_we_o,
    output logic                res_from_mem_o,
    output logic [XLEN-1:0]     pc_o,
    output logic                busy_o,
    output logic                fwd_valid_o,
    output logic [RD_W-1:0]     fwd_rd_o,
    output logic [XLEN-1:0]     fwd_data_o
);
    localparam int SHW = $clog2(XLEN);

    exe_state_e      state_q;
    logic            valid_q, hshake, accept;
    logic [XLEN-1:0] result_q, pc_q, alu_res, fast_res, div_res;
    logic [RD_W-1:0] rd_q;
    logic            gr_we_q, rfm_q;
    logic            div_slow, div_done;
    logic [SHW-1:0]  shamt;

    assign valid_q     = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign hshake      = out_valid_o && out_ready_i;
    assign in_ready_o  = !valid_q || hshake;
    // An instruction offered alongside a flush is dropped.
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign shamt       = src2_i[SHW-1:0];

    // Single-cycle integer ALU; LUI passes the pre-shifted immediate on src2.
    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLL:  alu_res = src1_i << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
            OP_XOR:  alu_res = src1_i ^ src2_i;
            OP_SRL:  alu_res = src1_i >> shamt;
            OP_SRA:  alu_res = $signed(src1_i) >>> shamt;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_AND:  alu_res = src1_i & src2_i;
            OP_LUI:  alu_res = src2_i;
            default: alu_res = '0;
        endcase
    end

`ifdef EXE_MULDIV_EN
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
    logic              a_sgn, b_sgn, is_div, div_signed, div_rem;
    logic              a_neg, b_neg, div_by_zero, div_ovf, div_busy;
    logic [XLEN-1:0]   a_mag, b_mag, q_mag, r_mag, min_val;
    logic              neg_q_q, neg_r_q, rem_sel_q;

    // Sign- or zero-extend to 2*XLEN so one unsigned multiply serves all four ops.
    assign a_sgn = (op_i == OP_MULH) || (op_i == OP_MULHSU);
    assign b_sgn = (op_i == OP_MULH);
    assign mul_a = {{XLEN{a_sgn & src1_i[XLEN-1]}}, src1_i};
    assign mul_b = {{XLEN{b_sgn & src2_i[XLEN-1]}}, src2_i};
    assign mul_p = mul_a * mul_b;

    assign min_val     = {1'b1, {(XLEN-1){1'b0}}};
    assign is_div      = (op_i == OP_DIV) || (op_i == OP_DIVU) ||
                         (op_i == OP_REM) || (op_i == OP_REMU);
    assign div_signed  = (op_i == OP_DIV) || (op_i == OP_REM);
    assign div_rem     = (op_i == OP_REM) || (op_i == OP_REMU);
    assign a_neg       = div_signed & src1_i[XLEN-1];
    assign b_neg       = div_signed & src2_i[XLEN-1];
    assign a_mag       = a_neg ? -src1_i : src1_i;
    assign b_mag       = b_neg ? -src2_i : src2_i;
    assign div_by_zero = (src2_i == '0);
    assign div_ovf     = div_signed && (src1_i == min_val) && (src2_i == '1);
    // Zero divisor and MIN/-1 have fixed answers and bypass the iterations.
    assign div_slow    = is_div && !div_by_zero && !div_ovf;

    // Result available at accept: ALU, multiply and the divide corner cases.
    always_comb begin
        fast_res = alu_res;
        case (op_i)
            OP_MUL:                       fast_res = mul_p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fast_res = mul_p[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fast_res = div_by_zero ? '1 : min_val;
            OP_REM, OP_REMU:              fast_res = div_by_zero ? src1_i : '0;
            default:                      fast_res = alu_res;
        endcase
    end

    // Remember which result and which sign corrections the divide needs at the end.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (accept) begin
            neg_q_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            rem_sel_q <= div_rem;
        end
    end

    assign div_res = rem_sel_q ? (neg_r_q ? -r_mag : r_mag)
                               : (neg_q_q ? -q_mag : q_mag);

    exe_divider #(.XLEN(XLEN)) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (accept && div_slow),
        .abort_i    (flush_i),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (q_mag),
        .rem_o      (r_mag)
    );

    assign busy_o = div_busy;
`else
    assign div_slow = 1'b0;
    assign div_done = 1'b0;
    assign div_res  = '0;
    assign fast_res = alu_res;
    assign busy_o   = 1'b0;
`endif

    // Stage control: flush wins, then accept, then drain, then divide completion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            rd_q     <= '0;
            gr_we_q  <= 1'b0;
            rfm_q    <= 1'b0;
            pc_q     <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
        end else if (accept) begin
            state_q  <= div_slow ? ST_DIV : ST_DONE;
            result_q <= fast_res;
            rd_q     <= rd_i;
            gr_we_q  <= gr_we_i;
            rfm_q    <= res_from_mem_i;
            pc_q     <= pc_i;
        end else if (hshake) begin
            state_q <= ST_IDLE;
        end else if ((state_q == ST_DIV) && div_done) begin
            state_q  <= ST_DONE;
            result_q <= div_res;
        end
    end

    assign result_o       = result_q;
    assign rd_o           = rd_q;
    assign gr_we_o        = gr_we_q;
    assign res_from_mem_o = rfm_q;
    assign pc_o           = pc_q;
    assign fwd_valid_o    = out_valid_o && gr_we_q && !rfm_q && (rd_q != '0);
    assign fwd_rd_o       = rd_q;
    assign fwd_data_o     = result_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_execute_stage;
    import exe_pkg::*;

    localparam int XLEN = 32;
    localparam int OPW  = 6;
    localparam int RDW  = 5;

    logic            clk = 1'b0, rst = 1'b0;
    logic            in_valid, in_ready, gr_we, res_from_mem, flush;
    logic            out_valid, out_ready, gr_we_q, rfm_q, busy, fwd_valid;
    logic [OPW-1:0]  op;
    logic [XLEN-1:0] src1, src2, pc, result, pc_q, fwd_data;
    logic [RDW-1:0]  rd, rd_q, fwd_rd;

    always #5 clk = ~clk;

    execute_stage #(.XLEN(XLEN), .ALU_OP_W(OPW), .RD_W(RDW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .src1_i(src1), .src2_i(src2), .rd_i(rd), .gr_we_i(gr_we),
        .res_from_mem_i(res_from_mem), .pc_i(pc), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .rd_o(rd_q), .gr_we_o(gr_we_q), .res_from_mem_o(rfm_q), .pc_o(pc_q),
        .busy_o(busy), .fwd_valid_o(fwd_valid), .fwd_rd_o(fwd_rd), .fwd_data_o(fwd_data)
    );

    int n_vec = 0, n_err = 0;

    // Model: the held instruction and how many edges remain until its result shows.
    bit          m_held = 0;
    int          m_rem  = 0;
    logic [31:0] m_res, m_pc;
    logic [4:0]  m_rd;
    bit          m_we, m_mem;

    function automatic logic [31:0] ref_result(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'(sa >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_LUI:  return b;
`ifdef EXE_MULDIV_EN
            OP_MUL:    return 32'(sa * sb);
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            OP_MULHU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : 32'(sa % sb);
            OP_REMU:   return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_slow(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef EXE_MULDIV_EN
        if (o < OP_DIV || o > OP_REMU) return 0;
        if (b == 0) return 0;
        if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 1;
`else
        return (o == 6'h3F) && (a == b) && (a != a);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit ev;
        ev = m_held && (m_rem == 0);
        check("in_ready", in_ready, !m_held || (ev && out_ready));
        check("out_valid", out_valid, ev);
        check("busy", busy, m_held && (m_rem >= 2));
        check("fwd_valid", fwd_valid, ev && m_we && !m_mem && (m_rd != 0));
        if (ev) begin
            check("result", result, m_res);
            check("rd", rd_q, m_rd);
            check("pc", pc_q, m_pc);
            check("gr_we", gr_we_q, m_we);
            check("res_from_mem", rfm_q, m_mem);
            check("fwd_rd", fwd_rd, m_rd);
            check("fwd_data", fwd_data, m_res);
        end
    endtask

    task automatic model_update();
        bit ev, rdy, acc;
        ev  = m_held && (m_rem == 0);
        rdy = !m_held || (ev && out_ready);
        acc = in_valid && rdy && !flush;
        if (flush) m_held = 0;
        else if (acc) begin
            m_held = 1;
            m_res  = ref_result(op, src1, src2);
            m_rd   = rd;  m_pc = pc;  m_we = gr_we;  m_mem = res_from_mem;
            m_rem  = ref_slow(op, src1, src2) ? XLEN + 1 : 0;
        end
        else if (ev && out_ready) m_held = 0;
        else if (m_held && m_rem > 0) m_rem--;
    endtask

    task automatic step(input bit v, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input bit we, input bit mem, input logic [31:0] p,
                        input bit ordy, input bit fl);
        in_valid = v; op = o; src1 = a; src2 = b; rd = r; gr_we = we;
        res_from_mem = mem; pc = p; out_ready = ordy; flush = fl;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, OP_ADD, 0, 0, 0, 0, 0, 0, ordy, 0);
    endtask

    // Accept one op, then wait (bounded) for its result; reports edges and busy cycles.
    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nb);
        step(1, o, a, b, 5'd7, 1, 0, 32'h200, 1, 0);
        lat = 0;
        nb  = busy ? 1 : 0;
        while (!out_valid && lat < 40) begin
            idle(1);
            lat++;
            if (busy) nb++;
        end
        check("op_completes", out_valid, 1);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 40) - 20;
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [19] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                             OP_OR, OP_AND, OP_LUI, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                             OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        in_valid = 0; op = '0; src1 = '0; src2 = '0; rd = '0; gr_we = 0;
        res_from_mem = 0; pc = '0; out_ready = 0; flush = 0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_rd", rd_q, 0);
        check("rst_pc", pc_q, 0);
        check("rst_busy", busy, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);

        // ADD 5+7 with one-cycle latency
        step(1, OP_ADD, 5, 7, 5'd1, 1, 0, 32'h100, 1, 0);
        check("add_result", result, 12);
        check("add_valid", out_valid, 1);

        // Ten back-to-back ALU ops at full rate
        for (int i = 0; i < 10; i++) begin
            step(1, ops[$urandom_range(0, 10)], $urandom, $urandom, 5'(i + 1), 1, 0, 32'(i * 4), 1, 0);
            check("b2b_in_ready", in_ready, 1);
        end
        idle(1);

        // Divide cases
        run_op(OP_DIV, -32'sd20, 32'd3, lat, nb);
`ifdef EXE_MULDIV_EN
        check("div_latency", lat, 33);
        check("div_busy_cycles", nb, 32);
        check("div_result", result, 32'hFFFF_FFFA);
`else
        check("div_latency", lat, 0);
        check("div_result", result, 0);
`endif
        run_op(OP_REM, -32'sd20, 32'd3, lat, nb);
`ifdef EXE_MULDIV_EN
        check("rem_result", result, 32'hFFFF_FFFE);
`else
        check("rem_result", result, 0);
`endif
        run_op(OP_DIVU, 32'd9, 32'd0, lat, nb);
        check("divu0_latency", lat, 0);
`ifdef EXE_MULDIV_EN
        check("divu0_result", result, 32'hFFFF_FFFF);
`endif
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        check("divovf_latency", lat, 0);
`ifdef EXE_MULDIV_EN
        check("divovf_result", result, 32'h8000_0000);
`endif
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        check("removf_result", result, 0);
        idle(1);

        // Output hold under back-pressure
        step(1, OP_ADD, 3, 4, 5'd5, 1, 0, 32'h300, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, OP_SUB, 9, 9, 5'd6, 1, 0, 32'h400, 0, 0);
            check("hold_result", result, 7);
            check("hold_rd", rd_q, 5);
            check("hold_pc", pc_q, 32'h300);
            check("hold_in_ready", in_ready, 0);
        end
        idle(1);

        // Flush during a divide
        step(1, OP_DIV, 32'd1000, 32'd7, 5'd2, 1, 0, 32'h500, 1, 0);
        for (int i = 0; i < 9; i++) idle(1);
        step(0, OP_ADD, 0, 0, 0, 0, 0, 0, 1, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        step(1, OP_ADD, 1, 1, 5'd2, 1, 0, 32'h504, 1, 0);
        check("post_flush_result", result, 2);
        check("post_flush_valid", out_valid, 1);
        idle(1);

        // Asynchronous reset during a divide
        step(1, OP_DIV, 32'd12345, 32'd17, 5'd9, 1, 0, 32'h600, 0, 0);
        for (int i = 0; i < 5; i++) idle(0);
        #2 rst = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_result", result, 0);
        check("arst_rd", rd_q, 0);
        check("arst_pc", pc_q, 0);
        check("arst_busy", busy, 0);
        check("arst_gr_we", gr_we_q, 0);
        m_held = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;

        // Forwarding qualifiers
        step(1, OP_ADD, 32'h1000, 32'd4, 5'd3, 1, 1, 32'h700, 1, 0);
        check("load_fwd_valid", fwd_valid, 0);
        step(1, OP_ADD, 32'd8, 32'd4, 5'd0, 1, 0, 32'h704, 1, 0);
        check("rd0_fwd_valid", fwd_valid, 0);
        step(1, OP_ADD, 32'd8, 32'd4, 5'd4, 1, 0, 32'h708, 1, 0);
        check("fwd_valid", fwd_valid, 1);
        check("fwd_data", fwd_data, 12);
        idle(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit fl;
            fl = ($urandom_range(0, 49) == 0);
            step(($urandom_range(0, 9) < 7) && (!fl || $urandom_range(0, 1) == 1),
                 ops[$urandom_range(0, 18)], rnd_operand(), rnd_operand(),
                 5'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom,
                 ($urandom_range(0, 9) < 8), fl);
        end
        for (int i = 0; i < 40; i++) idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
